pc_redirect_fetch: RTL and testbench
====================================

Name: pc_redirect_fetch

Overview:
- Consumer end of the branch-resolution interface: accepts the taken-branch/jump redirect (PcSel, BrPC) produced in EX and owns the fetch PC register.
- Sequences normal PC+4 fetch, honours hazard-unit stalls and instruction-memory backpressure, and holds a redirect pending when memory cannot accept it.
- Drives the IF/ID and ID/EX flushes and counts taken redirects for performance monitoring.
- Sits between the EX-stage branch logic and the instruction memory in the 5-stage pipeline.

Parameters:
- PC_W, 9: width of the PC register in bits; arithmetic wraps modulo 2^PC_W.
- RESET_PC, 0: PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  single design clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- PcSel  in  1  redirect request from the branch unit (taken branch, JAL or JALR).
- BrPC  in  32  redirect target; only bits [PC_W-1:0] are used.
- Stall  in  1  hazard-unit stall; holds the PC when no redirect is present.
- ImemReady  in  1  instruction memory accepts the current fetch this cycle.
- PC  out  PC_W  current fetch address.
- PC_Four  out  32  zero-extended (PC + 4) mod 2^PC_W, used as the link value.
- IfValid  out  1  the instruction fetched at PC this cycle may be latched into IF/ID.
- FlushIfId  out  1  clear the IF/ID register on this edge.
- FlushIdEx  out  1  clear the ID/EX register on this edge.
- MisalignErr  out  1  one-cycle pulse when the accepted target had BrPC[1:0] != 0.
- RedirectCnt  out  16  count of accepted redirects; saturates at 16'hFFFF.

Behaviour:
- Reset values: PC=RESET_PC, state=RUN, target register=0, RedirectCnt=0, MisalignErr=0, IfValid=0. IfValid remains 0 for the first cycle after reset is released.
- States:
  - RUN: normal fetch.
  - PENDING: a redirect has been captured but not yet applied.
- Target alignment: target = {BrPC[PC_W-1:2], 2'b00}. When BrPC[1:0] != 0, MisalignErr is registered high for exactly one cycle in the cycle after capture; the redirect still proceeds to the aligned target.
- RUN, PcSel=1:
  - FlushIfId and FlushIdEx are combinationally high in the same cycle.
  - RedirectCnt increments (saturating).
  - If ImemReady=1: PC <= target next edge; state stays RUN.
  - If ImemReady=0: latch target; state <= PENDING; PC is held.
  - PcSel has priority over Stall.
- RUN, PcSel=0:
  - Stall=1 or ImemReady=0: PC is held.
  - Otherwise: PC <= (PC + 4) mod 2^PC_W.
- PENDING:
  - IfValid=0 and PC is held.
  - ImemReady=1 and PcSel=0: PC <= latched target; state <= RUN.
  - A new PcSel=1: overwrites the latched target (latest redirect wins), pulses both flushes, and increments RedirectCnt. If ImemReady=1 in that same cycle, PC <= the new target and state <= RUN.
- IfValid = (state==RUN) && !PcSel && !Stall && ImemReady && (not first cycle after reset).
- Flushes are asserted only on redirects. Stall alone never flushes.
- PC_Four is combinational from PC.
- Wrap-around: with PC_W=9, PC=508 advances to 0. Targets are truncated to PC_W bits with no error.
- Reset asserted in any state (including PENDING) has priority: the pending target is discarded, PC=RESET_PC, flushes are deasserted, and the counter is cleared.
- Latency: redirect to new PC is 1 cycle when ImemReady=1; otherwise 1 cycle after the first cycle with ImemReady=1.

Test Plan:
- Reset for 2 cycles, then Stall=0, ImemReady=1 for 4 cycles -> PC sequence 0,4,8,12,16; IfValid=0 in the first cycle, then 1; PC_Four=PC+4; RedirectCnt=0.
- PC_W=9, run from PC=504 -> PC reaches 508, then wraps to 0 without error.
- At PC=100: PcSel=1, BrPC=120, Stall=1, ImemReady=1 -> FlushIfId=FlushIdEx=1 in that cycle; next PC=120 (redirect beats stall); RedirectCnt=1.
- At PC=100: PcSel=1, BrPC=200, ImemReady=0 held for 3 cycles -> state PENDING, PC stays 100, IfValid=0; the cycle ImemReady=1 -> next PC=200, back to RUN.
- Redirect with BrPC=122 -> PC=120, MisalignErr high for exactly one cycle.
- Enter PENDING with target 200; assert reset one cycle -> PC=0, RUN, RedirectCnt=0; subsequent ImemReady=1 never produces PC=200.

Source files
------------

// File: rtl/pc_redirect_fetch.sv
// pc_redirect_fetch: fetch PC owner and consumer of the EX-stage redirect.
// Sequences PC+4 fetch, stalls, imem backpressure, pending redirects,
// pipeline flushes and a saturating taken-redirect counter.
//
// Ports:
//   clk         design clock, rising edge
//   reset       synchronous active-high reset
//   PcSel       redirect request from the branch unit
//   BrPC        redirect target (low PC_W bits used, word aligned here)
//   Stall       hazard-unit stall, holds PC when no redirect
//   ImemReady   instruction memory accepts the fetch this cycle
//   PC          current fetch address
//   PC_Four     zero-extended (PC + 4) mod 2^PC_W, link value
//   IfValid     fetched instruction may be latched into IF/ID
//   FlushIfId   clear IF/ID on this edge
//   FlushIdEx   clear ID/EX on this edge
//   MisalignErr one-cycle pulse after accepting a misaligned target
//   RedirectCnt saturating count of accepted redirects
module pc_redirect_fetch #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic            ImemReady,
  output logic [PC_W-1:0] PC,
  output logic [31:0]     PC_Four,
  output logic            IfValid,
  output logic            FlushIfId,
  output logic            FlushIdEx,
  output logic            MisalignErr,
  output logic [15:0]     RedirectCnt
);

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam logic [PC_W-1:0] FOUR =
    {{(PC_W-3){1'b0}}, 3'b100};

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [PC_W-1:0] new_tgt;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            first_q;
  logic            unused_brpc;

  // Upper target bits beyond the PC width are dropped by design.
  assign unused_brpc = ^BrPC[31:PC_W];

  assign new_tgt = {BrPC[PC_W-1:2], 2'b00};
  assign pc_inc  = pc_q + FOUR;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      RUN: begin
        if (PcSel) begin
          if (ImemReady) begin
            pc_d = new_tgt;
          end else begin
            tgt_d   = new_tgt;
            state_d = PENDING;
          end
        end else if (!Stall && ImemReady) begin
          pc_d = pc_inc;
        end
      end
      PENDING: begin
        // A fresh redirect replaces the held one.
        if (PcSel) begin
          tgt_d = new_tgt;
          if (ImemReady) begin
            pc_d    = new_tgt;
            state_d = RUN;
          end
        end else if (ImemReady) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (PcSel && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    mis_d = PcSel && (BrPC[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      first_q <= 1'b0;
    end
  end

  assign PC          = pc_q;
  assign PC_Four     = {{(32-PC_W){1'b0}}, pc_inc};
  assign FlushIfId   = PcSel && !reset;
  assign FlushIdEx   = PcSel && !reset;
  assign MisalignErr = mis_q;
  assign RedirectCnt = cnt_q;

  // First cycle after reset release never presents a valid fetch.
  assign IfValid = (state_q == RUN) && !PcSel && !Stall
                && ImemReady && !first_q;

endmodule

// File: tb/tb_pc_redirect_fetch.sv
// tb_pc_redirect_fetch: scoreboard bench for pc_redirect_fetch.
// Directed plan cases, counter saturation and random traffic.
module tb_pc_redirect_fetch;

  localparam int PC_W = 9;
  localparam int MODV = 1 << PC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            PcSel = 1'b0;
  logic [31:0]     BrPC = '0;
  logic            Stall = 1'b0;
  logic            ImemReady = 1'b0;
  logic [PC_W-1:0] PC;
  logic [31:0]     PC_Four;
  logic            IfValid;
  logic            FlushIfId;
  logic            FlushIdEx;
  logic            MisalignErr;
  logic [15:0]     RedirectCnt;

  pc_redirect_fetch #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC),
    .Stall(Stall), .ImemReady(ImemReady), .PC(PC),
    .PC_Four(PC_Four), .IfValid(IfValid),
    .FlushIfId(FlushIfId), .FlushIdEx(FlushIdEx),
    .MisalignErr(MisalignErr), .RedirectCnt(RedirectCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int pc4;
    bit ifv;
    bit fl;
    bit mis;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int m_pc, m_tgt, m_cnt;
  bit m_pend, m_mis, m_first;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit ps,
                       input logic [31:0] br,
                       input bit st, input bit rdy);
    exp_t e;
    int   t;
    @(negedge clk);
    reset = rst; PcSel = ps; BrPC = br;
    Stall = st; ImemReady = rdy;
    if (rst) begin
      m_pc = 0; m_tgt = 0; m_cnt = 0;
      m_pend = 0; m_mis = 0; m_first = 1;
    end else begin
      e.pc  = m_pc;
      e.pc4 = (m_pc + 4) % MODV;
      e.ifv = !m_pend && !ps && !st && rdy && !m_first;
      e.fl  = ps;
      e.mis = m_mis;
      e.cnt = m_cnt;
      sbq.push_back(e);
      t = int'(br % MODV) / 4 * 4;
      m_first = 0;
      m_mis = ps && (br % 4 != 0);
      if (ps && m_cnt < 65535) m_cnt++;
      if (ps) begin
        if (rdy) begin m_pc = t; m_pend = 0; end
        else begin m_tgt = t; m_pend = 1; end
      end else if (m_pend) begin
        if (rdy) begin m_pc = m_tgt; m_pend = 0; end
      end else if (!st && rdy) begin
        m_pc = (m_pc + 4) % MODV;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("PC", 32'(PC), 32'(e.pc));
        chk("PC_Four", PC_Four, 32'(e.pc4));
        chk("IfValid", 32'(IfValid), 32'(e.ifv));
        chk("FlushIfId", 32'(FlushIfId), 32'(e.fl));
        chk("FlushIdEx", 32'(FlushIdEx), 32'(e.fl));
        chk("MisalignErr", 32'(MisalignErr), 32'(e.mis));
        chk("RedirectCnt", 32'(RedirectCnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    int budget;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 1);
    // redirect beats stall
    drive(0, 1, 100, 0, 1);
    drive(0, 1, 120, 1, 1);
    drive(0, 0, 0, 0, 1);
    // pending redirect under backpressure
    drive(0, 1, 100, 0, 1);
    drive(0, 1, 200, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    // misaligned target
    drive(0, 1, 122, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    // wrap-around and truncated target
    drive(0, 1, 504, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    drive(0, 1, 32'hFFFF_F1F8, 0, 1);
    drive(0, 0, 0, 0, 1);
    // reset discards a pending target
    drive(0, 1, 200, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 1);
    // latest redirect wins while pending
    drive(0, 1, 300, 0, 0);
    drive(0, 1, 401, 1, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    // counter saturation
    for (int i = 0; i < 65540; i++)
      drive(0, 1, $urandom, 0, $urandom_range(0, 1));
    repeat (3) drive(0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < 7);
    budget = 10;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
